// File: rtl/hqa_col_metric.sv
// hqa_col_metric: matched-filter projection Re{col^H y} and squared norm
// ||col||^2 for the two H*A product columns, using one shared MAC over 8 steps.
// Optional feature macro: HQA_METRIC_SAT_EN (clamp results instead of wrapping).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   col0_r/i, col1_r/i        product columns, 4 x Q8.8, element 0 in MSBs
//   y_r/i                     received vector, same packing
//   in_valid                  level; a rising edge starts a computation
//   proj0/1, norm0/1          Q8.8 results, held until the next result
//   out_valid                 one-cycle result strobe
//   busy                      high from capture until out_valid
//   sat_flag                  a result was clamped in the last computation
module hqa_col_metric #(
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 36
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4*DW-1:0] col0_r,
    input  logic [4*DW-1:0] col0_i,
    input  logic [4*DW-1:0] col1_r,
    input  logic [4*DW-1:0] col1_i,
    input  logic [4*DW-1:0] y_r,
    input  logic [4*DW-1:0] y_i,
    input  logic            in_valid,
    output logic [DW-1:0]   proj0,
    output logic [DW-1:0]   proj1,
    output logic [DW-1:0]   norm0,
    output logic [DW-1:0]   norm1,
    output logic            out_valid,
    output logic            busy,
    output logic            sat_flag
);

    typedef enum logic [1:0] {IDLE, ACC, FIN, DONE} state_t;

    state_t state;
    logic   in_valid_d;
    logic [2:0] step;

    logic [4*DW-1:0] c0r_q, c0i_q, c1r_q, c1i_q, yr_q, yi_q;
    logic signed [ACC_W-1:0] pacc0, pacc1, nacc0, nacc1;
    logic [DW-1:0] res_p0, res_p1, res_n0, res_n1;
    logic          res_sat;

    // Element select: column from step[2], element k = step[1:0]
    // (element 0 sits in the MSBs, hence the inverted index).
    logic [1:0]      idx;
    logic [4*DW-1:0] sel_r, sel_i;
    logic signed [DW-1:0] cr, ci, yr, yi;

    assign idx   = ~step[1:0];
    assign sel_r = step[2] ? c1r_q : c0r_q;
    assign sel_i = step[2] ? c1i_q : c0i_q;
    assign cr    = sel_r[idx*DW +: DW];
    assign ci    = sel_i[idx*DW +: DW];
    assign yr    = yr_q[idx*DW +: DW];
    assign yi    = yi_q[idx*DW +: DW];

    logic signed [2*DW-1:0] p_ry, p_iy, p_rr, p_ii;
    assign p_ry = cr * yr;
    assign p_iy = ci * yi;
    assign p_rr = cr * cr;
    assign p_ii = ci * ci;

    function automatic logic signed [ACC_W-1:0] ext(input logic signed [2*DW-1:0] v);
        return {{(ACC_W-2*DW){v[2*DW-1]}}, v};
    endfunction

    logic signed [ACC_W-1:0] pterm, nterm;
    assign pterm = ext(p_ry) + ext(p_iy);
    assign nterm = ext(p_rr) + ext(p_ii);

    // Final reduction of the four accumulators to DW bits.
    logic [DW-1:0] red_p0, red_p1, red_n0, red_n1;
    logic          red_sat;

`ifdef HQA_METRIC_SAT_EN
    localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((64'sd1 <<< (DW-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] PMIN = -PMAX - ACC_W'(1);

    // Returns {clamped, value}.
    function automatic logic [DW:0] clamp_p(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC;
        if (sh > PMAX)
            return {1'b1, PMAX[DW-1:0]};
        else if (sh < PMIN)
            return {1'b1, PMIN[DW-1:0]};
        else
            return {1'b0, sh[DW-1:0]};
    endfunction

    function automatic logic [DW:0] clamp_n(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC;
        if (sh > PMAX)
            return {1'b1, PMAX[DW-1:0]};
        else if (sh < 0)
            return {1'b1, {DW{1'b0}}};
        else
            return {1'b0, sh[DW-1:0]};
    endfunction

    logic [DW:0] cp0, cp1, cn0, cn1;
    always_comb begin
        cp0     = clamp_p(pacc0);
        cp1     = clamp_p(pacc1);
        cn0     = clamp_n(nacc0);
        cn1     = clamp_n(nacc1);
        red_p0  = cp0[DW-1:0];
        red_p1  = cp1[DW-1:0];
        red_n0  = cn0[DW-1:0];
        red_n1  = cn1[DW-1:0];
        red_sat = cp0[DW] | cp1[DW] | cn0[DW] | cn1[DW];
    end
`else
    // Wrap: low DW bits of the arithmetic shift by FRAC.
    always_comb begin
        red_p0  = pacc0[FRAC +: DW];
        red_p1  = pacc1[FRAC +: DW];
        red_n0  = nacc0[FRAC +: DW];
        red_n1  = nacc1[FRAC +: DW];
        red_sat = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_valid_d <= 1'b0;
            step       <= '0;
            c0r_q      <= '0;
            c0i_q      <= '0;
            c1r_q      <= '0;
            c1i_q      <= '0;
            yr_q       <= '0;
            yi_q       <= '0;
            pacc0      <= '0;
            pacc1      <= '0;
            nacc0      <= '0;
            nacc1      <= '0;
            res_p0     <= '0;
            res_p1     <= '0;
            res_n0     <= '0;
            res_n1     <= '0;
            res_sat    <= 1'b0;
            proj0      <= '0;
            proj1      <= '0;
            norm0      <= '0;
            norm1      <= '0;
            sat_flag   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            in_valid_d <= in_valid;
            out_valid  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid && !in_valid_d) begin
                        c0r_q <= col0_r;
                        c0i_q <= col0_i;
                        c1r_q <= col1_r;
                        c1i_q <= col1_i;
                        yr_q  <= y_r;
                        yi_q  <= y_i;
                        pacc0 <= '0;
                        pacc1 <= '0;
                        nacc0 <= '0;
                        nacc1 <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (step[2]) begin
                        pacc1 <= pacc1 + pterm;
                        nacc1 <= nacc1 + nterm;
                    end else begin
                        pacc0 <= pacc0 + pterm;
                        nacc0 <= nacc0 + nterm;
                    end
                    step <= step + 3'd1;
                    if (step == 3'd7)
                        state <= FIN;
                end
                FIN: begin
                    res_p0  <= red_p0;
                    res_p1  <= red_p1;
                    res_n0  <= red_n0;
                    res_n1  <= red_n1;
                    res_sat <= red_sat;
                    state   <= DONE;
                end
                DONE: begin
                    proj0     <= res_p0;
                    proj1     <= res_p1;
                    norm0     <= res_n0;
                    norm1     <= res_n1;
                    sat_flag  <= res_sat;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hqa_col_metric.sv
// tb_hqa_col_metric: scoreboard bench for hqa_col_metric.
// Expected results are queued at stimulus time and compared on out_valid.
module tb_hqa_col_metric;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] col0_r, col0_i, col1_r, col1_i, y_r, y_i;
    logic        in_valid;
    logic [15:0] proj0, proj1, norm0, norm1;
    logic        out_valid, busy, sat_flag;

    always #5 clk = ~clk;

    hqa_col_metric dut (
        .clk(clk), .rst(rst),
        .col0_r(col0_r), .col0_i(col0_i),
        .col1_r(col1_r), .col1_i(col1_i),
        .y_r(y_r), .y_i(y_i),
        .in_valid(in_valid),
        .proj0(proj0), .proj1(proj1),
        .norm0(norm0), .norm1(norm1),
        .out_valid(out_valid), .busy(busy), .sat_flag(sat_flag)
    );

    typedef struct {
        logic [15:0] p0, p1, n0, n1;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   n_ov     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint el(input logic [63:0] v, input int k);
        logic signed [15:0] e;
        e = v[63-16*k -: 16];
        return longint'(e);
    endfunction

    function automatic logic [15:0] reduce(input longint a, input bit is_norm, output bit s);
        longint sh;
        logic [63:0] u;
        sh = a >>> 8;
        u  = sh;
        s  = 1'b0;
`ifdef HQA_METRIC_SAT_EN
        if (sh > 32767) begin
            s = 1'b1;
            return 16'h7FFF;
        end
        if (!is_norm && sh < -32768) begin
            s = 1'b1;
            return 16'h8000;
        end
        if (is_norm && sh < 0) begin
            s = 1'b1;
            return 16'h0000;
        end
`endif
        return u[15:0];
    endfunction

    task automatic push_exp();
        longint p[2], n[2];
        logic [63:0] cr, ci;
        exp_t e;
        bit s0, s1, s2, s3;
        for (int c = 0; c < 2; c++) begin
            cr = (c == 0) ? col0_r : col1_r;
            ci = (c == 0) ? col0_i : col1_i;
            p[c] = 0;
            n[c] = 0;
            for (int k = 0; k < 4; k++) begin
                p[c] += el(cr, k) * el(y_r, k) + el(ci, k) * el(y_i, k);
                n[c] += el(cr, k) * el(cr, k) + el(ci, k) * el(ci, k);
            end
        end
        e.p0  = reduce(p[0], 1'b0, s0);
        e.p1  = reduce(p[1], 1'b0, s1);
        e.n0  = reduce(n[0], 1'b1, s2);
        e.n1  = reduce(n[1], 1'b1, s3);
        e.sat = s0 | s1 | s2 | s3;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            n_ov++;
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("proj0", 32'(proj0), 32'(e.p0));
                check("proj1", 32'(proj1), 32'(e.p1));
                check("norm0", 32'(norm0), 32'(e.n0));
                check("norm1", 32'(norm1), 32'(e.n1));
                check("sat_flag", 32'(sat_flag), 32'(e.sat));
            end
        end
    end

    task automatic set_in(input logic [63:0] a, b, c, d, e, f);
        col0_r = a;
        col0_i = b;
        col1_r = c;
        col1_i = d;
        y_r    = e;
        y_i    = f;
    endtask

    // Drive at a negedge so the following posedge is the capture edge E0.
    task automatic kick(input bit push);
        @(negedge clk);
        in_valid = 1'b1;
        if (push) push_exp();
    endtask

    task automatic wait_ov(output int cyc, output int busy_n);
        cyc    = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) busy_n++;
        end while (!out_valid && cyc < 40);
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    int cyc, bn, ov0;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        set_in('0, '0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst_proj0", 32'(proj0), 32'd0);
        check("rst_norm1", 32'(norm1), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;

        // basic projection
        set_in(64'h0100_0000_0000_0000, '0, '0, '0,
               64'h0200_0000_0000_0000, '0);
        kick(1'b1);
        wait_ov(cyc, bn);
        check("basic_latency", 32'(cyc), 32'd11);
        check("basic_busy_cycles", 32'(bn), 32'd10);
        check("basic_proj0_const", 32'(proj0), 32'h0200);
        check("basic_norm0_const", 32'(norm0), 32'h0100);
        @(negedge clk);
        check("basic_pulse_width", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // complex cancellation
        set_in('0, '0, {4{16'h0100}}, {4{16'h0100}},
               {4{16'h0100}}, {4{16'hFF00}});
        kick(1'b1);
        wait_ov(cyc, bn);
        check("cancel_proj1_const", 32'(proj1), 32'h0000);
        check("cancel_norm1_const", 32'(norm1), 32'h0800);
        check("cancel_sat_const", 32'(sat_flag), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;

        // saturation
        set_in({4{16'h7FFF}}, {4{16'h7FFF}}, '0, '0, '0, '0);
        kick(1'b1);
        wait_ov(cyc, bn);
`ifdef HQA_METRIC_SAT_EN
        check("sat_norm0_const", 32'(norm0), 32'h7FFF);
        check("sat_flag_const", 32'(sat_flag), 32'd1);
`else
        check("wrap_norm0_const", 32'(norm0), 32'hF800);
        check("wrap_flag_const", 32'(sat_flag), 32'd0);
`endif
        @(negedge clk);
        in_valid = 1'b0;

        // random patterns
        for (int i = 0; i < 4; i++) begin
            set_in(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64());
            kick(1'b1);
            wait_ov(cyc, bn);
            check("rand_latency", 32'(cyc), 32'd11);
            @(negedge clk);
            in_valid = 1'b0;
        end

        // busy guard: re-edge in_valid mid computation with other inputs
        ov0 = n_ov;
        set_in(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64());
        kick(1'b1);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        set_in(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64());
        in_valid = 1'b1;
        wait_ov(cyc, bn);
        repeat (15) @(negedge clk);
        check("guard_one_out_valid", 32'(n_ov - ov0), 32'd1);
        check("guard_queue_empty", 32'(sb.size()), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);

        // mid-op reset with in_valid held high through reset
        set_in(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64());
        ov0 = n_ov;
        kick(1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_proj0", 32'(proj0), 32'd0);
        check("mrst_norm0", 32'(norm0), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_no_out_valid", 32'(n_ov - ov0), 32'd0);
        push_exp();
        rst = 1'b0;
        wait_ov(cyc, bn);
        check("mrst_restart_latency", 32'(cyc), 32'd11);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);

        // back-to-back: second rising edge lands on E11
        set_in(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64());
        kick(1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov(cyc, bn);
        set_in(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64());
        in_valid = 1'b1;
        push_exp();
        wait_ov(cyc, bn);
        check("b2b_gap", 32'(cyc), 32'd11);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
